// File: rtl/nic_host_port.sv
// Processor-side initiator for one cardinal_nic register interface.
// Moves host TX packets into the NIC output channel and NIC input-channel
// packets onto the host RX stream, using status polling before every access.
module nic_host_port #(
   parameter int unsigned DW = 64,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tx_valid,
   input  logic [DW-1:0] tx_data,
   output logic          tx_ready,
   output logic          rx_valid,
   output logic [DW-1:0] rx_data,
   input  logic          rx_ready,
   output logic [1:0]    addr,
   output logic [DW-1:0] d_in,
   output logic          nicEn,
   output logic          nicWrEn,
   input  logic [DW-1:0] d_out,
   output logic [CW-1:0] tx_count,
   output logic [CW-1:0] rx_count
);

   typedef enum logic [2:0] {
      StIdle, StTxStat, StTxChk, StTxWr, StRxStat, StRxChk, StRxRd, StRxCap
   } state_e;

   localparam logic [1:0] AddrInBuf   = 2'b00;
   localparam logic [1:0] AddrInStat  = 2'b01;
   localparam logic [1:0] AddrOutBuf  = 2'b10;
   localparam logic [1:0] AddrOutStat = 2'b11;

   state_e        state_q, state_d;
   logic          tx_full_q, tx_full_d;
   logic [DW-1:0] tx_buf_q, tx_buf_d;
   logic          rx_full_q, rx_full_d;
   logic [DW-1:0] rx_buf_q, rx_buf_d;
   logic [CW-1:0] tx_count_q, tx_count_d;
   logic [CW-1:0] rx_count_q, rx_count_d;
   logic          last_rx_q, last_rx_d;  // 1 = last sequence started was RX
   logic          nic_en_q, nic_en_d;
   logic          nic_wr_en_q, nic_wr_en_d;
   logic [1:0]    addr_q, addr_d;
   logic [DW-1:0] d_in_q, d_in_d;
   logic          want_tx, want_rx;

   assign want_tx = tx_full_q;
   assign want_rx = ~rx_full_q;

   // Next state, holding registers, counters, and NIC outputs decoded from next state
   always_comb begin
      state_d     = state_q;
      tx_full_d   = tx_full_q;
      tx_buf_d    = tx_buf_q;
      rx_full_d   = rx_full_q;
      rx_buf_d    = rx_buf_q;
      tx_count_d  = tx_count_q;
      rx_count_d  = rx_count_q;
      last_rx_d   = last_rx_q;

      if (tx_valid && !tx_full_q) begin
         tx_full_d = 1'b1;
         tx_buf_d  = tx_data;
      end
      if (rx_full_q && rx_ready) begin
         rx_full_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            // Round-robin: when both are pending, serve the one not served last
            if (want_tx && (!want_rx || last_rx_q)) begin
               state_d   = StTxStat;
               last_rx_d = 1'b0;
            end else if (want_rx) begin
               state_d   = StRxStat;
               last_rx_d = 1'b1;
            end
         end
         StTxStat: state_d = StTxChk;
         StTxChk:  state_d = d_out[0] ? StIdle : StTxWr;
         StTxWr: begin
            // tx_full is set throughout the sequence, so no host load can collide
            tx_full_d  = 1'b0;
            tx_count_d = tx_count_q + CW'(1);
            state_d    = StIdle;
         end
         StRxStat: state_d = StRxChk;
         StRxChk:  state_d = d_out[0] ? StRxRd : StIdle;
         StRxRd:   state_d = StRxCap;
         StRxCap: begin
            rx_buf_d   = d_out;
            rx_full_d  = 1'b1;
            rx_count_d = rx_count_q + CW'(1);
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase

      nic_en_d    = 1'b0;
      nic_wr_en_d = 1'b0;
      addr_d      = AddrInBuf;
      d_in_d      = '0;
      unique case (state_d)
         StTxStat: begin
            nic_en_d = 1'b1;
            addr_d   = AddrOutStat;
         end
         StTxWr: begin
            nic_en_d    = 1'b1;
            nic_wr_en_d = 1'b1;
            addr_d      = AddrOutBuf;
            d_in_d      = tx_buf_q;
         end
         StRxStat: begin
            nic_en_d = 1'b1;
            addr_d   = AddrInStat;
         end
         StRxRd: begin
            nic_en_d = 1'b1;
            addr_d   = AddrInBuf;
         end
         default: ;
      endcase
   end

   // State and registered outputs; synchronous reset discards both holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         tx_full_q   <= 1'b0;
         tx_buf_q    <= '0;
         rx_full_q   <= 1'b0;
         rx_buf_q    <= '0;
         tx_count_q  <= '0;
         rx_count_q  <= '0;
         last_rx_q   <= 1'b1;
         nic_en_q    <= 1'b0;
         nic_wr_en_q <= 1'b0;
         addr_q      <= AddrInBuf;
         d_in_q      <= '0;
      end else begin
         state_q     <= state_d;
         tx_full_q   <= tx_full_d;
         tx_buf_q    <= tx_buf_d;
         rx_full_q   <= rx_full_d;
         rx_buf_q    <= rx_buf_d;
         tx_count_q  <= tx_count_d;
         rx_count_q  <= rx_count_d;
         last_rx_q   <= last_rx_d;
         nic_en_q    <= nic_en_d;
         nic_wr_en_q <= nic_wr_en_d;
         addr_q      <= addr_d;
         d_in_q      <= d_in_d;
      end
   end

   assign tx_ready = ~tx_full_q;
   assign rx_valid = rx_full_q;
   assign rx_data  = rx_buf_q;
   assign nicEn    = nic_en_q;
   assign nicWrEn  = nic_wr_en_q;
   assign addr     = addr_q;
   assign d_in     = d_in_q;
   assign tx_count = tx_count_q;
   assign rx_count = rx_count_q;

endmodule

// File: tb/tb_nic_host_port.sv
// Directed bench for nic_host_port with a small reactive NIC register model.
module tb_nic_host_port;

   localparam int unsigned DW = 64;
   localparam int unsigned CW = 4;  // small counters so wrap is reachable quickly

   logic          clk = 1'b0;
   logic          reset;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_ready;
   logic          rx_valid;
   logic [DW-1:0] rx_data;
   logic          rx_ready;
   logic [1:0]    addr;
   logic [DW-1:0] d_in;
   logic          nicEn;
   logic          nicWrEn;
   logic [DW-1:0] d_out = '0;
   logic [CW-1:0] tx_count;
   logic [CW-1:0] rx_count;

   int checks   = 0;
   int failures = 0;

   nic_host_port #(.DW(DW), .CW(CW)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .addr     (addr),
      .d_in     (d_in),
      .nicEn    (nicEn),
      .nicWrEn  (nicWrEn),
      .d_out    (d_out),
      .tx_count (tx_count),
      .rx_count (rx_count)
   );

   always #5 clk = ~clk;

   // NIC model: registered read data, input channel full while pushed != popped,
   // output status reports busy for out_busy_lim - out_busy_seen polls.
   int unsigned   in_pushed = 0;
   int unsigned   in_popped = 0;
   int unsigned   out_busy_lim = 0;
   int unsigned   out_busy_seen = 0;
   logic [DW-1:0] in_data = '0;

   always @(posedge clk) begin
      if (nicEn && !nicWrEn) begin
         case (addr)
            2'b00: begin
               d_out <= in_data;
               if (in_pushed != in_popped) in_popped <= in_popped + 1;
            end
            2'b01: d_out <= {63'b0, (in_pushed != in_popped)};
            2'b11: begin
               if (out_busy_seen < out_busy_lim) begin
                  d_out         <= 64'd1;
                  out_busy_seen <= out_busy_seen + 1;
               end else begin
                  d_out <= '0;
               end
            end
            default: d_out <= '0;
         endcase
      end else begin
         d_out <= '0;
      end
   end

   // Bus monitor
   int            cyc = 0;
   int            wr_cnt = 0;
   int            wr_cyc = 0;
   int            wr_bad = 0;
   int            idle_bad = 0;
   int            rx_polls = 0;
   int            tx_polls = 0;
   int            rd_cnt = 0;
   int            rxv_cyc = 0;
   logic          rxv_prev = 1'b0;
   logic          wr_txrdy = 1'b0;
   logic [DW-1:0] wr_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (nicEn && nicWrEn) begin
            wr_cnt   <= wr_cnt + 1;
            wr_data  <= d_in;
            wr_cyc   <= cyc;
            wr_txrdy <= tx_ready;
            if (addr != 2'b10) wr_bad <= wr_bad + 1;
         end
         if (nicEn && !nicWrEn && addr == 2'b01) rx_polls <= rx_polls + 1;
         if (nicEn && !nicWrEn && addr == 2'b11) tx_polls <= tx_polls + 1;
         if (nicEn && !nicWrEn && addr == 2'b00) rd_cnt <= rd_cnt + 1;
         if (!nicEn && (nicWrEn || addr != 2'b00 || d_in != '0)) idle_bad <= idle_bad + 1;
         if (rx_valid && !rxv_prev) rxv_cyc <= cyc;
         rxv_prev <= rx_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [DW-1:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (tx_ready) break;
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int a_cyc;
   int w0;
   int tp0;
   int rp0;
   int rd0;
   int gap;
   int rdy_bad;

   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      rx_ready = 1'b0;
      tick(); tick(); tick();

      // Reset state
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_nic", {nicEn, nicWrEn, addr}, 0);
      chk("rst_d_in", d_in, 0);
      chk("rst_counts", {tx_count, rx_count}, 0);

      // Idle: RX status polls every 3 cycles, nothing else
      reset = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      chk("idle_rx_polls", rx_polls, 10);
      chk("idle_tx_polls", tx_polls, 0);
      chk("idle_no_write", wr_cnt, 0);
      chk("idle_tx_ready", tx_ready, 1);
      chk("idle_rx_valid", rx_valid, 0);
      chk("idle_counts", {tx_count, rx_count}, 0);

      // Single TX, NIC output empty; accept on the RX_CHK edge so IDLE follows
      for (int i = 0; i < 10; i++) begin
         if (nicEn && addr == 2'b01) break;
         tick();
      end
      tick();
      tx_valid = 1'b1;
      tx_data  = 64'h8000_0000_DEAD_BEEF;
      tick();
      a_cyc    = cyc;
      tx_valid = 1'b0;
      chk("tx_ready_low", tx_ready, 0);
      for (int i = 0; i < 20; i++) begin
         if (wr_cnt == 1) break;
         tick();
      end
      chk("tx1_wr_cnt", wr_cnt, 1);
      chk("tx1_wr_data", wr_data, 64'h8000_0000_DEAD_BEEF);
      chk("tx1_latency", wr_cyc - a_cyc, 3);
      chk("tx1_rdy_in_wr", wr_txrdy, 0);
      chk("tx1_ready_back", tx_ready, 1);
      chk("tx1_count", tx_count, 1);

      // TX with output channel busy for three polls
      out_busy_lim = out_busy_seen + 3;
      tp0 = tx_polls;
      rp0 = rx_polls;
      w0  = wr_cnt;
      rdy_bad = 0;
      tx_valid = 1'b1;
      tx_data  = 64'h1122_3344_5566_7788;
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (wr_cnt != w0) break;
         if (tx_ready) rdy_bad++;
         tick();
      end
      chk("busy_wr_cnt", wr_cnt - w0, 1);
      chk("busy_tx_polls", tx_polls - tp0, 4);
      chk("busy_rx_interleave", (rx_polls - rp0) >= 3, 1);
      chk("busy_wr_data", wr_data, 64'h1122_3344_5566_7788);
      chk("busy_ready_held", rdy_bad, 0);
      chk("busy_count", tx_count, 2);

      // RX with host not ready
      in_data = 64'h0123_4567_89AB_CDEF;
      in_pushed++;
      rd0 = rd_cnt;
      for (int i = 0; i < 20; i++) begin
         if (rx_valid) break;
         tick();
      end
      chk("rx_valid", rx_valid, 1);
      chk("rx_data", rx_data, 64'h0123_4567_89AB_CDEF);
      chk("rx_count", rx_count, 1);
      chk("rx_reads", rd_cnt - rd0, 1);
      rp0 = rx_polls;
      for (int i = 0; i < 20; i++) tick();
      chk("rx_no_polls_full", rx_polls - rp0, 0);
      chk("rx_valid_held", rx_valid, 1);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("rx_popped", rx_valid, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("rx_polls_resume", rx_polls > rp0, 1);

      // TX pending and NIC input full at once
      in_data = 64'hCAFE_0000_0000_0002;
      in_pushed++;
      w0 = wr_cnt;
      tx_valid = 1'b1;
      tx_data  = 64'h0000_0000_0000_0003;
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (wr_cnt != w0 && rx_valid) break;
         tick();
      end
      chk("both_wr", wr_cnt - w0, 1);
      chk("both_rx", rx_valid, 1);
      gap = (wr_cyc > rxv_cyc) ? wr_cyc - rxv_cyc : rxv_cyc - wr_cyc;
      chk("both_gap_le8", gap <= 8, 1);
      chk("both_rx_data", rx_data, 64'hCAFE_0000_0000_0002);
      chk("both_wr_data", wr_data, 64'h0000_0000_0000_0003);
      chk("both_counts", {tx_count, rx_count}, {4'd3, 4'd2});
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;

      // Reset during TX_CHK: no write may follow
      w0 = wr_cnt;
      tx_valid = 1'b1;
      tx_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      tx_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (nicEn && addr == 2'b11) break;
         tick();
      end
      chk("rst_seq_saw_txstat", {nicEn, addr}, 3'b111);
      tick();
      reset = 1'b1;
      tick();
      tick();
      chk("rst_mid_nic", {nicEn, nicWrEn}, 0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("rst_mid_no_write", wr_cnt - w0, 0);
      chk("rst_mid_tx_ready", tx_ready, 1);
      chk("rst_mid_counts", {tx_count, rx_count}, 0);

      // Counter wrap
      for (int n = 1; n <= 15; n++) send(64'(n));
      chk("wrap_15", tx_count, 15);
      send(64'h0000_0000_0000_00AA);
      chk("wrap_0", tx_count, 0);
      chk("wrap_last_data", wr_data, 64'h0000_0000_0000_00AA);

      // Global bus sanity
      chk("bad_wr_addr", wr_bad, 0);
      chk("idle_outputs_nonzero", idle_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
